or1k_spr_cfg_port: RTL and testbench

SPR bus slave for the group-0 configuration registers. It decodes SPR accesses from the CTRL unit's SPR bus, selects the matching configuration word from the constant outputs of the configuration-register block, and returns it with a registered one-shot acknowledge. It sits directly downstream of the configuration-register block and upstream of the CTRL unit's SPR read-data OR-mux.

---
 rtl/or1k_spr_cfg_port.sv | 145 ++++++++++++++
 tb/tb_or1k_spr_cfg_port.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/or1k_spr_cfg_port.sv
// SPR bus slave for the group-0 configuration registers (VR..AVR).
// Optional write-error pulse output enabled by macro OR1K_SPR_CFG_WR_ERR_EN.
//
// Ports:
//   cpu_clk, cpu_rst_n     clock, async active-low reset
//   pipeline_flush_i       aborts any pending access
//   spr_bus_*_i            SPR bus request from CTRL
//   spr_*_i                constant configuration words
//   spr_bus_dat_cfg_o      registered read data (0 unless acking)
//   spr_bus_ack_cfg_o      registered one-cycle acknowledge
//   spr_cfg_wr_err_o       write-attempt pulse (macro builds only)
module or1k_spr_cfg_port #(
  parameter logic [4:0] OPTION_SPR_CFG_GROUP  = 5'd0,
  parameter int         OPTION_CFG_LAST_INDEX = 10
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst_n,
  input  logic        pipeline_flush_i,
  input  logic [15:0] spr_bus_addr_i,
  input  logic        spr_bus_we_i,
  input  logic        spr_bus_stb_i,
  input  logic [31:0] spr_bus_dat_i,
  input  logic [31:0] spr_vr_i,
  input  logic [31:0] spr_upr_i,
  input  logic [31:0] spr_cpucfgr_i,
  input  logic [31:0] spr_dmmucfgr_i,
  input  logic [31:0] spr_immucfgr_i,
  input  logic [31:0] spr_dccfgr_i,
  input  logic [31:0] spr_iccfgr_i,
  input  logic [31:0] spr_dcfgr_i,
  input  logic [31:0] spr_pccfgr_i,
  input  logic [31:0] spr_vr2_i,
  input  logic [31:0] spr_avr_i,
  output logic [31:0] spr_bus_dat_cfg_o,
  output logic        spr_bus_ack_cfg_o
`ifdef OR1K_SPR_CFG_WR_ERR_EN
  ,
  output logic        spr_cfg_wr_err_o
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam logic [10:0] LAST_IDX =
    11'(OPTION_CFG_LAST_INDEX);

  state_t      state_q;
  state_t      state_d;
  logic        ack_q;
  logic        ack_d;
  logic [31:0] dat_q;
  logic [31:0] dat_d;
  logic        wr_err_q;
  logic        wr_err_d;
  logic        hit;
  logic [31:0] mux_word;
  logic        unused_ok;

  assign hit = spr_bus_stb_i &
    (spr_bus_addr_i[15:11] == OPTION_SPR_CFG_GROUP) &
    (spr_bus_addr_i[10:0] <= LAST_IDX);

  // Indices above 10 never hit, so the low nibble
  // is enough to select the word.
  always_comb begin
    mux_word = 32'h0;
    case (spr_bus_addr_i[3:0])
      4'd0:    mux_word = spr_vr_i;
      4'd1:    mux_word = spr_upr_i;
      4'd2:    mux_word = spr_cpucfgr_i;
      4'd3:    mux_word = spr_dmmucfgr_i;
      4'd4:    mux_word = spr_immucfgr_i;
      4'd5:    mux_word = spr_dccfgr_i;
      4'd6:    mux_word = spr_iccfgr_i;
      4'd7:    mux_word = spr_dcfgr_i;
      4'd8:    mux_word = spr_pccfgr_i;
      4'd9:    mux_word = spr_vr2_i;
      4'd10:   mux_word = spr_avr_i;
      default: mux_word = 32'h0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    ack_d    = 1'b0;
    dat_d    = 32'h0;
    wr_err_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (hit) begin
          state_d  = ACK;
          ack_d    = 1'b1;
          dat_d    = spr_bus_we_i ? 32'h0 : mux_word;
          wr_err_d = spr_bus_we_i;
        end
      end
      ACK: begin
        state_d = spr_bus_stb_i ? WAIT : IDLE;
      end
      WAIT: begin
        if (!spr_bus_stb_i)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Flush wins over everything: no capture,
    // and any pending handshake is abandoned.
    if (pipeline_flush_i) begin
      state_d  = IDLE;
      ack_d    = 1'b0;
      dat_d    = 32'h0;
      wr_err_d = 1'b0;
    end
  end

  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state_q  <= IDLE;
      ack_q    <= 1'b0;
      dat_q    <= 32'h0;
      wr_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ack_q    <= ack_d;
      dat_q    <= dat_d;
      wr_err_q <= wr_err_d;
    end
  end

  assign spr_bus_ack_cfg_o = ack_q;
  assign spr_bus_dat_cfg_o = dat_q;

  // Registers are read-only: write data is never used.
`ifdef OR1K_SPR_CFG_WR_ERR_EN
  assign spr_cfg_wr_err_o = wr_err_q;
  assign unused_ok = ^spr_bus_dat_i;
`else
  assign unused_ok = ^{spr_bus_dat_i, wr_err_q};
`endif

endmodule

// File: tb/tb_or1k_spr_cfg_port.sv
// Directed self-checking bench for or1k_spr_cfg_port.
// Covers reads, sweep, misses, writes, flush and async reset.
module tb_or1k_spr_cfg_port;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] addr = 16'h0;
  logic        we = 1'b0;
  logic        stb = 1'b0;
  logic [31:0] wdat = 32'h0;
  logic [31:0] cfg [11];
  logic [31:0] dat;
  logic        ack;
  logic [31:0] dat8;
  logic        ack8;
`ifdef OR1K_SPR_CFG_WR_ERR_EN
  logic        err;
  logic        err8;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int cnt_a;
  int cnt_b;

  always #5 clk = ~clk;

  or1k_spr_cfg_port u_dut (
    .cpu_clk          (clk),
    .cpu_rst_n        (rst_n),
    .pipeline_flush_i (flush),
    .spr_bus_addr_i   (addr),
    .spr_bus_we_i     (we),
    .spr_bus_stb_i    (stb),
    .spr_bus_dat_i    (wdat),
    .spr_vr_i         (cfg[0]),
    .spr_upr_i        (cfg[1]),
    .spr_cpucfgr_i    (cfg[2]),
    .spr_dmmucfgr_i   (cfg[3]),
    .spr_immucfgr_i   (cfg[4]),
    .spr_dccfgr_i     (cfg[5]),
    .spr_iccfgr_i     (cfg[6]),
    .spr_dcfgr_i      (cfg[7]),
    .spr_pccfgr_i     (cfg[8]),
    .spr_vr2_i        (cfg[9]),
    .spr_avr_i        (cfg[10]),
    .spr_bus_dat_cfg_o(dat),
    .spr_bus_ack_cfg_o(ack)
`ifdef OR1K_SPR_CFG_WR_ERR_EN
    ,
    .spr_cfg_wr_err_o (err)
`endif
  );

  or1k_spr_cfg_port #(
    .OPTION_CFG_LAST_INDEX(8)
  ) u_dut8 (
    .cpu_clk          (clk),
    .cpu_rst_n        (rst_n),
    .pipeline_flush_i (flush),
    .spr_bus_addr_i   (addr),
    .spr_bus_we_i     (we),
    .spr_bus_stb_i    (stb),
    .spr_bus_dat_i    (wdat),
    .spr_vr_i         (cfg[0]),
    .spr_upr_i        (cfg[1]),
    .spr_cpucfgr_i    (cfg[2]),
    .spr_dmmucfgr_i   (cfg[3]),
    .spr_immucfgr_i   (cfg[4]),
    .spr_dccfgr_i     (cfg[5]),
    .spr_iccfgr_i     (cfg[6]),
    .spr_dcfgr_i      (cfg[7]),
    .spr_pccfgr_i     (cfg[8]),
    .spr_vr2_i        (cfg[9]),
    .spr_avr_i        (cfg[10]),
    .spr_bus_dat_cfg_o(dat8),
    .spr_bus_ack_cfg_o(ack8)
`ifdef OR1K_SPR_CFG_WR_ERR_EN
    ,
    .spr_cfg_wr_err_o (err8)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  // One read: stb for one cycle, ack next cycle,
  // then idle with everything back at zero.
  task automatic do_read(input logic [15:0] a,
                         input logic [31:0] exp,
                         input string tag);
    addr = a;
    we   = 1'b0;
    stb  = 1'b1;
    tick();
    chk({tag, "_ack"}, {31'h0, ack}, 32'h1);
    chk({tag, "_dat"}, dat, exp);
    stb = 1'b0;
    tick();
    chk({tag, "_ack0"}, {31'h0, ack}, 32'h0);
    chk({tag, "_dat0"}, dat, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 11; i++)
      cfg[i] = 32'h1000_0000 + i;
    #3;
    chk("rst_ack", {31'h0, ack}, 32'h0);
    chk("rst_dat", dat, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // Read CPUCFGR with stb held three cycles
    cfg[2] = 32'h0000_0620;
    addr = 16'h0002;
    stb  = 1'b1;
    tick();
    chk("cpucfgr_ack", {31'h0, ack}, 32'h1);
    chk("cpucfgr_dat", dat, 32'h0000_0620);
    cfg[2] = 32'hDEAD_BEEF;
    tick();
    chk("cpucfgr_ack_w1", {31'h0, ack}, 32'h0);
    chk("cpucfgr_dat_w1", dat, 32'h0);
    tick();
    chk("cpucfgr_ack_w2", {31'h0, ack}, 32'h0);
    chk("cpucfgr_dat_w2", dat, 32'h0);
    stb = 1'b0;
    tick();
    chk("cpucfgr_ack_end", {31'h0, ack}, 32'h0);

    // Sweep all indices with distinct patterns
    for (int i = 0; i < 11; i++)
      cfg[i] = 32'hA5A5_0000 + i;
    for (int i = 0; i < 11; i++)
      do_read(16'(i), 32'hA5A5_0000 + i,
              $sformatf("sweep%0d", i));

    // LAST_INDEX=8 instance must ignore 9 and 10
    for (int j = 9; j < 11; j++) begin
      addr  = 16'(j);
      stb   = 1'b1;
      cnt_a = 0;
      cnt_b = 0;
      for (int k = 0; k < 10; k++) begin
        tick();
        if (ack)  cnt_a++;
        if (ack8) cnt_b++;
      end
      stb = 1'b0;
      tick();
      chk($sformatf("last8_miss%0d", j), 32'(cnt_b), 32'h0);
      chk($sformatf("once_%0d", j), 32'(cnt_a), 32'h1);
    end

    // Misses: index 17 and group 1
    addr = 16'h0011;
    stb  = 1'b1;
    cnt_a = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (ack || dat != 32'h0) cnt_a++;
    end
    chk("miss_idx17", 32'(cnt_a), 32'h0);
    addr = 16'h0802;
    cnt_a = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (ack || dat != 32'h0) cnt_a++;
    end
    chk("miss_grp1", 32'(cnt_a), 32'h0);
    stb = 1'b0;
    tick();

    // Write to UPR: acked with zero data
    addr = 16'h0001;
    we   = 1'b1;
    wdat = 32'hFFFF_FFFF;
    stb  = 1'b1;
    tick();
    chk("wr_ack", {31'h0, ack}, 32'h1);
    chk("wr_dat", dat, 32'h0);
`ifdef OR1K_SPR_CFG_WR_ERR_EN
    chk("wr_err", {31'h0, err}, 32'h1);
`endif
    stb = 1'b0;
    we  = 1'b0;
    tick();
    chk("wr_ack0", {31'h0, ack}, 32'h0);
`ifdef OR1K_SPR_CFG_WR_ERR_EN
    chk("wr_err0", {31'h0, err}, 32'h0);
`endif
    do_read(16'h0001, 32'hA5A5_0001, "upr_after_wr");

    // Flush in the capture cycle
    addr  = 16'h0000;
    stb   = 1'b1;
    flush = 1'b1;
    tick();
    chk("flush_cap_ack", {31'h0, ack}, 32'h0);
    chk("flush_cap_dat", dat, 32'h0);
    flush = 1'b0;
    stb   = 1'b0;
    tick();
    chk("flush_cap_ack2", {31'h0, ack}, 32'h0);

    // Flush in the ACK cycle with stb still high:
    // FSM must land in IDLE, not WAIT, so the held
    // stb is captured again on the next edge.
    stb = 1'b1;
    tick();
    chk("flush_ack_vis", {31'h0, ack}, 32'h1);
    chk("flush_ack_dat", dat, 32'hA5A5_0000);
    flush = 1'b1;
    tick();
    chk("flush_ack_gone", {31'h0, ack}, 32'h0);
    chk("flush_ack_dat0", dat, 32'h0);
    flush = 1'b0;
    tick();
    chk("flush_reack", {31'h0, ack}, 32'h1);
    chk("flush_reack_dat", dat, 32'hA5A5_0000);
    stb = 1'b0;
    tick();

    // Async reset mid-cycle while in ACK
    addr = 16'h000A;
    stb  = 1'b1;
    tick();
    chk("pre_rst_ack", {31'h0, ack}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ack", {31'h0, ack}, 32'h0);
    chk("arst_dat", dat, 32'h0);
    stb = 1'b0;
    tick();
    #2;
    rst_n = 1'b1;
    tick();
    do_read(16'h000A, 32'hA5A5_000A, "avr_after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
